imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/loader_csum.sv | 34 +++
 rtl/imem_loader.sv | 157 +++++++++++++++
 tb/tb_imem_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// State encoding and stream header size.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_e;

    // Word-count header length in bytes.
    localparam int HDR_LEN = 2;

    // States in which the loader consumes stream bytes.
    function automatic logic takes_bytes(input state_e s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) ||
               (s == ST_DATA)   || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/loader_csum.sv
// Running XOR checksum register with synchronous clear and enable.
// Ports: clk, rst_n, clr, en, din[7:0] in; csum[7:0] out.
module loader_csum (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] csum
);

    logic [7:0] csum_q;
    logic [7:0] csum_d;

    always_comb begin
        csum_d = csum_q;
        if (clr) begin
            csum_d = '0;
        end else if (en) begin
            csum_d = csum_q ^ din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Byte-stream writer for imem: header N, 4N data bytes, XOR checksum.
// Ports: start/in_data/in_valid in, in_ready out; mem_we/addr/wdata write
// port; cpu_hold, done, error status.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int NW        = 8 * HDR_LEN;
    localparam int CW        = ADDR_W + 1;
    localparam int MAX_WORDS = (1 << (ADDR_W - 2)) - BASE_ADDR / 4;

    state_e              state_q, state_d;
    logic [NW-1:0]       n_q, n_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_wdata_q, mem_wdata_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic                accept;
    logic                csum_clr;
    logic                csum_en;
    logic [7:0]          csum;
    logic [NW-1:0]       n_full;
    logic                oversize;
    logic                last_byte;

    assign accept   = in_valid & in_ready_q;
    assign n_full   = {n_q[NW-1:8], in_data};
    assign oversize = {1'b0, n_full} > (NW+1)'(MAX_WORDS);
    // Byte index 4N-1 closes the data phase.
    assign last_byte = (NW+2)'(cnt_q) == ({n_q, 2'b00} - (NW+2)'(1));

    loader_csum u_csum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (csum_clr),
        .en    (csum_en),
        .din   (in_data),
        .csum  (csum)
    );

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        csum_clr    = 1'b0;
        csum_en     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d  = ST_LEN_HI;
                    cnt_d    = '0;
                    csum_clr = 1'b1;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    n_d[NW-1:8] = in_data;
                    state_d     = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    n_d[7:0] = in_data;
                    if (oversize) begin
                        state_d = ST_ERROR;
                    end else if (n_full == '0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ADDR_W'(BASE_ADDR) + cnt_q[ADDR_W-1:0];
                    mem_wdata_d = in_data;
                    csum_en     = 1'b1;
                    cnt_d       = cnt_q + CW'(1);
                    if (last_byte) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_d = (in_data == csum) ? ST_DONE : ST_ERROR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Status flags are registered views of the next state.
        in_ready_d = takes_bytes(state_d);
        done_d     = (state_d == ST_DONE);
        error_d    = (state_d == ST_ERROR);
        cpu_hold_d = !done_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued at stimulus,
// popped and compared by a monitor on every mem_we.
module tb_imem_loader;

    localparam int ADDR_W = 10;
    localparam int BASE   = 0;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    int checks   = 0;
    int failures = 0;
    int we_cnt   = 0;

    logic [ADDR_W+7:0] exp_q[$];
    logic [7:0]        img[$];

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            we_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected: got %0h:%0h expected none",
                         mem_addr, mem_wdata);
            end else begin
                logic [ADDR_W+7:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    failures++;
                    $display("FAIL wr: got %0h:%0h expected %0h:%0h",
                             mem_addr, mem_wdata, e[ADDR_W+7:8], e[7:0]);
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        int t;
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got in_ready=0 expected 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run_load(input logic [15:0] n, input logic [7:0] cs,
                            input bit gap);
        pulse_start();
        send(n[15:8], gap);
        send(n[7:0], gap);
        for (int i = 0; i < img.size(); i++) begin
            exp_q.push_back({ADDR_W'(BASE + i), img[i]});
            send(img[i], gap);
        end
        send(cs, gap);
    endtask

    task automatic set_img_a();
        img = '{8'h20, 8'h10, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h08};
    endtask

    initial begin
        int w0;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_hold", cpu_hold, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic image, back-to-back.
        set_img_a();
        w0 = we_cnt;
        run_load(16'h0002, 8'h3C, 1'b0);
        chk("a_done", done, 1);
        chk("a_hold", cpu_hold, 0);
        chk("a_error", error, 0);
        chk("a_in_ready", in_ready, 0);
        chk("a_writes", we_cnt - w0, 8);

        // Same image with in_valid gaps.
        w0 = we_cnt;
        run_load(16'h0002, 8'h3C, 1'b1);
        chk("gap_done", done, 1);
        chk("gap_writes", we_cnt - w0, 8);

        // Bad checksum, then recover.
        run_load(16'h0002, 8'h3D, 1'b0);
        chk("bad_error", error, 1);
        chk("bad_hold", cpu_hold, 1);
        chk("bad_done", done, 0);
        run_load(16'h0002, 8'h3C, 1'b0);
        chk("rec_done", done, 1);
        chk("rec_error", error, 0);

        // Oversize word count.
        w0 = we_cnt;
        pulse_start();
        send(8'h01, 1'b0);
        send(8'h01, 1'b0);
        chk("ovr_error", error, 1);
        chk("ovr_in_ready", in_ready, 0);
        chk("ovr_hold", cpu_hold, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("ovr_writes", we_cnt - w0, 0);

        // Maximum legal count boundary: 256 words is accepted.
        img = {};
        for (int i = 0; i < 1024; i++) img.push_back(8'(i * 7 + 3));
        begin
            logic [7:0] x;
            x = 8'h00;
            for (int i = 0; i < 1024; i++) x = x ^ img[i];
            w0 = we_cnt;
            run_load(16'h0100, x, 1'b0);
        end
        chk("max_done", done, 1);
        chk("max_writes", we_cnt - w0, 1024);

        // Empty image.
        img = {};
        w0 = we_cnt;
        run_load(16'h0000, 8'h00, 1'b0);
        chk("n0_done", done, 1);
        chk("n0_writes", we_cnt - w0, 0);
        run_load(16'h0000, 8'h01, 1'b0);
        chk("n0_bad_error", error, 1);
        chk("n0_bad_done", done, 0);

        // Reset in the middle of the data phase.
        set_img_a();
        pulse_start();
        send(8'h00, 1'b0);
        send(8'h02, 1'b0);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({ADDR_W'(BASE + i), img[i]});
            send(img[i], 1'b0);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_in_ready", in_ready, 0);
        chk("mid_mem_we", mem_we, 0);
        chk("mid_mem_addr", mem_addr, 0);
        chk("mid_mem_wdata", mem_wdata, 0);
        chk("mid_cpu_hold", cpu_hold, 1);
        chk("mid_done", done, 0);
        chk("mid_error", error, 0);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        w0 = we_cnt;
        run_load(16'h0002, 8'h08, 1'b0);
        chk("post_done", done, 1);
        chk("post_hold", cpu_hold, 0);
        chk("post_writes", we_cnt - w0, 8);

        repeat (3) @(posedge clk);
        #1;
        chk("exp_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
